trackball_emu: RTL and testbench

- Converts the digital 8-way joystick into emulated trackball position counts for the Centipede/Millipede core.
- Sits directly upstream of the core's trakball_i input; it replaces the unconnected trackball register in the sim top and the MiSTer top.
- Two independent axes (horizontal, vertical). Each axis has a velocity ramp, so a held direction accelerates like a spun ball.
- Output freezes while the CPU is paused (pause/hiscore system).

---
 rtl/trackball_pkg.sv | 10 +
 rtl/trackball_axis.sv | 71 +++++++
 rtl/trackball_emu.sv | 55 +++++
 tb/tb_trackball_emu.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/trackball_pkg.sv
// trackball_pkg: shared types and constants for the joystick-to-trackball emulator.
package trackball_pkg;
    typedef enum logic [1:0] {IDLE, RAMP, CRUISE} axis_state_e;
    localparam int VEL_W     = 3;
    localparam int POS_W     = 4;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_UP    = 0;
endpackage

// File: rtl/trackball_axis.sv
// trackball_axis: one emulated trackball axis with a velocity ramp and wrapping 4-bit position.
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int ACCEL_TICKS = 32,
    parameter int START_SPEED = 1,
    parameter int MAX_SPEED   = 4
) (
    input  logic             clk_12,
    input  logic             reset,
    input  logic             tick,
    input  logic             pos_req,
    input  logic             neg_req,
    output logic [POS_W-1:0] position,
    output logic             dir
);
    localparam int ACC_W = ACCEL_TICKS > 1 ? $clog2(ACCEL_TICKS) : 1;
    axis_state_e      state_q, state_d;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             active, acc_last;
    assign active   = pos_req ^ neg_req;
    assign acc_last = acc_q == ACC_W'(ACCEL_TICKS - 1);
    assign position = pos_q;
    assign dir      = dir_q;
    always_ff @(posedge clk_12) begin
        if (reset) begin
            state_q <= IDLE;
            vel_q   <= '0;
            acc_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vel_q   <= vel_d;
            acc_q   <= acc_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end
    // A fresh press and a reversal both restart the ramp in the requested direction.
    always_comb begin
        state_d = state_q;
        vel_d   = vel_q;
        acc_d   = acc_q;
        dir_d   = dir_q;
        if (tick) begin
            if (!active) begin
                state_d = IDLE;
                vel_d   = '0;
                acc_d   = '0;
            end else if (state_q == IDLE || neg_req != dir_q) begin
                state_d = START_SPEED == MAX_SPEED ? CRUISE : RAMP;
                vel_d   = VEL_W'(START_SPEED);
                acc_d   = '0;
                dir_d   = neg_req;
            end else if (state_q == RAMP) begin
                vel_d   = acc_last ? vel_q + VEL_W'(1) : vel_q;
                acc_d   = acc_last ? '0 : acc_q + ACC_W'(1);
                state_d = vel_d == VEL_W'(MAX_SPEED) ? CRUISE : RAMP;
            end
        end
    end
    always_comb begin
        pos_d = pos_q;
        if (tick && state_d != IDLE)
            pos_d = dir_d ? pos_q - POS_W'(vel_d) : pos_q + POS_W'(vel_d);
    end
endmodule

// File: rtl/trackball_emu.sv
// trackball_emu: turns the 8-way joystick into emulated trackball counts for the core.
module trackball_emu
    import trackball_pkg::*;
#(
    parameter int TICK_DIV    = 12000,
    parameter int ACCEL_TICKS = 32,
    parameter int START_SPEED = 1,
    parameter int MAX_SPEED   = 4
) (
    input  logic       clk_12,
    input  logic       reset,
    input  logic       pause,
    input  logic [3:0] joystick_n,
    output logic [7:0] trakball_o,
    output logic [1:0] dir_o,
    output logic       tick_o
);
    localparam int CNT_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       joy_q;
    logic [POS_W-1:0] h_pos, v_pos;
    logic             h_dir, v_dir;
    assign tick_o     = !pause && cnt_q == CNT_LAST;
    assign cnt_d      = pause ? cnt_q : (cnt_q == CNT_LAST ? '0 : cnt_q + CNT_W'(1));
    assign trakball_o = {h_pos, v_pos};
    assign dir_o      = {h_dir, v_dir};
    always_ff @(posedge clk_12) begin
        if (reset) begin
            joy_q <= '0;
            cnt_q <= '0;
        end else begin
            joy_q <= ~joystick_n;
            cnt_q <= cnt_d;
        end
    end
    trackball_axis #(.ACCEL_TICKS(ACCEL_TICKS), .START_SPEED(START_SPEED), .MAX_SPEED(MAX_SPEED)) u_h (
        .clk_12   (clk_12),
        .reset    (reset),
        .tick     (tick_o),
        .pos_req  (joy_q[JOY_RIGHT]),
        .neg_req  (joy_q[JOY_LEFT]),
        .position (h_pos),
        .dir      (h_dir)
    );
    trackball_axis #(.ACCEL_TICKS(ACCEL_TICKS), .START_SPEED(START_SPEED), .MAX_SPEED(MAX_SPEED)) u_v (
        .clk_12   (clk_12),
        .reset    (reset),
        .tick     (tick_o),
        .pos_req  (joy_q[JOY_DOWN]),
        .neg_req  (joy_q[JOY_UP]),
        .position (v_pos),
        .dir      (v_dir)
    );
endmodule

// File: tb/tb_trackball_emu.sv
// tb_trackball_emu: directed scenarios for trackball_emu with a 4-cycle tick and short ramp.
module tb_trackball_emu;
    logic       clk_12 = 1'b0;
    logic       reset = 1'b1;
    logic       pause = 1'b0;
    logic [3:0] joystick_n = 4'hF;
    logic [7:0] trakball_o;
    logic [1:0] dir_o;
    logic       tick_o;
    int checks = 0;
    int errors = 0;

    trackball_emu #(.TICK_DIV(4), .ACCEL_TICKS(2), .START_SPEED(1), .MAX_SPEED(3)) dut (
        .clk_12     (clk_12),
        .reset      (reset),
        .pause      (pause),
        .joystick_n (joystick_n),
        .trakball_o (trakball_o),
        .dir_o      (dir_o),
        .tick_o     (tick_o)
    );

    always #5 clk_12 = ~clk_12;

    // Returns on the negedge after a tick, when the updated position is visible.
    task automatic wait_tick;
        int n = 0;
        do begin
            @(negedge clk_12);
            n++;
        end while (tick_o !== 1'b1 && n < 16);
        checks++;
        if (tick_o !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout: got tick_o=%b after %0d cycles, required 1", tick_o, n);
        end
        @(negedge clk_12);
    endtask

    task automatic apply_reset;
        joystick_n = 4'hF;
        pause = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk_12);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk_12);
        checks++;
        if (trakball_o !== 8'h00 || dir_o !== 2'b00 || tick_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got trak=%h dir=%b tick=%b, required 00 00 0", trakball_o, dir_o, tick_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_right_ramp;
        logic [3:0] e [8] = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2};
        apply_reset();
        joystick_n = 4'b0111;
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            checks++;
            if (trakball_o !== {e[i], 4'h0} || dir_o !== 2'b00) begin
                errors++;
                $display("FAIL right_ramp tick %0d: got trak=%h dir=%b, required %h 00", i, trakball_o, dir_o, {e[i], 4'h0});
            end
        end
    endtask

    task automatic test_left_wrap;
        logic [3:0] e [3] = '{4'd15, 4'd14, 4'd12};
        apply_reset();
        joystick_n = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            checks++;
            if (trakball_o !== {e[i], 4'h0} || dir_o !== 2'b10) begin
                errors++;
                $display("FAIL left_wrap tick %0d: got trak=%h dir=%b, required %h 10", i, trakball_o, dir_o, {e[i], 4'h0});
            end
        end
    endtask

    task automatic test_reversal;
        logic [3:0] e [3] = '{4'd8, 4'd7, 4'd5};
        apply_reset();
        joystick_n = 4'b0111;
        repeat (5) wait_tick();
        checks++;
        if (trakball_o !== 8'h90) begin
            errors++;
            $display("FAIL reversal_cruise: got trak=%h, required 90", trakball_o);
        end
        // Restart at speed 1 after reversal, then ramp 1,2
        joystick_n = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            checks++;
            if (trakball_o !== {e[i], 4'h0} || dir_o !== 2'b10) begin
                errors++;
                $display("FAIL reversal tick %0d: got trak=%h dir=%b, required %h 10", i, trakball_o, dir_o, {e[i], 4'h0});
            end
        end
    endtask

    task automatic test_both_and_diag;
        apply_reset();
        joystick_n = 4'b0011;
        repeat (4) begin
            wait_tick();
            checks++;
            if (trakball_o !== 8'h00) begin
                errors++;
                $display("FAIL both_sides: got trak=%h, required 00", trakball_o);
            end
        end
        joystick_n = 4'b0101;
        repeat (2) wait_tick();
        checks++;
        if (trakball_o !== 8'h22 || dir_o !== 2'b00) begin
            errors++;
            $display("FAIL diagonal: got trak=%h dir=%b, required 22 00", trakball_o, dir_o);
        end
    endtask

    task automatic test_pause;
        logic bad = 1'b0;
        apply_reset();
        joystick_n = 4'b1110;
        wait_tick();
        wait_tick();
        wait_tick();
        checks++;
        if (trakball_o !== 8'h0C || dir_o !== 2'b01) begin
            errors++;
            $display("FAIL up_ramp: got trak=%h dir=%b, required 0c 01", trakball_o, dir_o);
        end
        repeat (3) @(negedge clk_12);
        pause = 1'b1;
        #1;
        checks++;
        if (tick_o !== 1'b0) begin
            errors++;
            $display("FAIL pause_tick_mask: got tick_o=%b, required 0", tick_o);
        end
        repeat (20) begin
            @(negedge clk_12);
            if (tick_o !== 1'b0 || trakball_o !== 8'h0C) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL pause_hold: got tick=%b trak=%h, required 0 0c", tick_o, trakball_o);
        end
        pause = 1'b0;
        #1;
        checks++;
        if (tick_o !== 1'b1) begin
            errors++;
            $display("FAIL pause_divider_frozen: got tick_o=%b, required 1", tick_o);
        end
        @(negedge clk_12);
        checks++;
        if (trakball_o !== 8'h0A) begin
            errors++;
            $display("FAIL pause_resume: got trak=%h, required 0a", trakball_o);
        end
    endtask

    task automatic test_reset_mid_cruise;
        int n = 0;
        apply_reset();
        joystick_n = 4'b1011;
        repeat (6) wait_tick();
        checks++;
        if (trakball_o !== 8'h40 || dir_o !== 2'b10) begin
            errors++;
            $display("FAIL cruise_left: got trak=%h dir=%b, required 40 10", trakball_o, dir_o);
        end
        do begin
            @(negedge clk_12);
            n++;
        end while (tick_o !== 1'b1 && n < 16);
        reset = 1'b1;
        @(negedge clk_12);
        checks++;
        if (trakball_o !== 8'h00 || dir_o !== 2'b00 || tick_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_cruise: got trak=%h dir=%b tick=%b, required 00 00 0", trakball_o, dir_o, tick_o);
        end
        reset = 1'b0;
        joystick_n = 4'hF;
        wait_tick();
        checks++;
        if (trakball_o !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset: got trak=%h, required 00", trakball_o);
        end
        joystick_n = 4'b1110;
        wait_tick();
        checks++;
        if (trakball_o !== 8'h0F || dir_o !== 2'b01) begin
            errors++;
            $display("FAIL restart_after_reset: got trak=%h dir=%b, required 0f 01", trakball_o, dir_o);
        end
    endtask

    initial begin
        test_reset();
        test_right_ramp();
        test_left_wrap();
        test_reversal();
        test_both_and_diag();
        test_pause();
        test_reset_mid_cruise();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
